// File: rtl/axi4_fb_pkg.sv
// axi4_fb_pkg: FSM states, AXI constants and burst sizing
// shared by the frame-buffer master slice.
package axi4_fb_pkg;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ADDR,
    W_DATA,
    W_RESP
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } r_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [3:0] AXI_ID         = 4'd0;

  function automatic logic [2:0] axi_size(input int data_w);
    return 3'($clog2(data_w / 8));
  endfunction

  function automatic int burst_bytes(input int burst_len,
                                     input int data_w);
    return burst_len * data_w / 8;
  endfunction

endpackage

// File: rtl/axi4_fb_master_if.sv
// axi4_fb_master_if: AXI4 AW/W/B/AR/R bundle.
// Ports: master drives addr/data/valid, slave drives ready/resp.
interface axi4_fb_master_if #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 28
);
  logic [3:0]          awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic [3:0]          awqos;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [3:0]          bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  logic [3:0]          arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic [3:0]          arqos;
  logic                arvalid;
  logic                arready;

  logic [3:0]          rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst,
           awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst,
           arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst,
           awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst,
           arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi4_fb_addr_gen.sv
// axi4_fb_addr_gen: frame offset and buffer-ring tracker.
// Ports: step (burst issued), restart/restart_idx, addr, buf_idx, frame_end.
module axi4_fb_addr_gen #(
  parameter int          ADDR_W      = 28,
  parameter int unsigned FRAME_BYTES = 1920*1080*2,
  parameter int unsigned BURST_BYTES = 256,
  parameter int          FB_NUM      = 3,
  parameter int unsigned FB_BASE     = 0,
  parameter bit          RING_ADV    = 1'b1
) (
  input  logic              sclk,
  input  logic              s_rst,
  input  logic              step,
  input  logic              restart,
  input  logic [1:0]        restart_idx,
  output logic [ADDR_W-1:0] addr,
  output logic [1:0]        buf_idx,
  output logic              frame_end
);

  localparam logic [ADDR_W-1:0] FRAME_A  = ADDR_W'(FRAME_BYTES);
  localparam logic [ADDR_W-1:0] BURST_A  = ADDR_W'(BURST_BYTES);
  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(FB_BASE);
  localparam logic [ADDR_W-1:0] LAST_OFF = FRAME_A - BURST_A;
  localparam logic [1:0]        LAST_IDX = 2'(FB_NUM - 1);

  logic [ADDR_W-1:0] offset;
  logic              at_end;

  assign at_end    = (offset == LAST_OFF);
  assign frame_end = step & at_end;

  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      offset  <= '0;
      buf_idx <= 2'd0;
    end else if (restart) begin
      offset  <= '0;
      buf_idx <= restart_idx;
    end else if (step) begin
      if (at_end) begin
        offset <= '0;
        // the read side wraps within its buffer; only writes rotate
        if (RING_ADV)
          buf_idx <= (buf_idx == LAST_IDX) ? 2'd0 : buf_idx + 2'd1;
      end else begin
        offset <= offset + BURST_A;
      end
    end
  end

  assign addr = BASE_A + ADDR_W'(buf_idx) * FRAME_A + offset;

endmodule

// File: rtl/axi4_fb_master.sv
// axi4_fb_master: frame-buffer AXI4 burst master, FIFO-fed write and read.
// Ports: sclk/s_rst, m_axi bus, FIFO side, buf indices, resp_err (AXI4_FB_RESP_CHK_EN).
module axi4_fb_master
  import axi4_fb_pkg::*;
#(
  parameter int          DATA_W      = 128,
  parameter int          ADDR_W      = 28,
  parameter int          BURST_LEN   = 16,
  parameter int unsigned FRAME_BYTES = 1920*1080*2,
  parameter int          FB_NUM      = 3,
  parameter int unsigned FB_BASE     = 0
) (
  input  logic              sclk,
  input  logic              s_rst,
  axi4_fb_master_if.master  m_axi,
  input  logic              wr_trig,
  output logic              wfifo_rd_en,
  input  logic [DATA_W-1:0] wfifo_rd_data,
  input  logic              rd_trig,
  input  logic              rd_vsync,
  output logic              rfifo_wr_en,
  output logic [DATA_W-1:0] rfifo_wr_data,
  output logic [1:0]        wr_buf_idx,
  output logic [1:0]        rd_buf_idx,
  output logic [1:0]        resp_err
);

  localparam int unsigned BB = burst_bytes(BURST_LEN, DATA_W);
  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

  w_state_t w_st, w_nx;
  r_state_t r_st, r_nx;

  logic [7:0]        beat;
  logic              aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic              wr_frame_end;
  logic              rd_wrap_unused;
  logic [1:0]        last_done;
  logic [2:0]        vs_q;
  logic              vs_rise, vs_pend, rd_restart;
  logic [1:0]        rd_load_idx;
  logic              unused_in;

  assign m_axi.awid    = AXI_ID;
  assign m_axi.awaddr  = wr_addr;
  assign m_axi.awlen   = LAST_BEAT;
  assign m_axi.awsize  = axi_size(DATA_W);
  assign m_axi.awburst = AXI_BURST_INCR;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = 4'd0;
  assign m_axi.awprot  = 3'd0;
  assign m_axi.awqos   = 4'd0;
  assign m_axi.wstrb   = '1;
  assign m_axi.wdata   = wfifo_rd_data;
  assign m_axi.wlast   = (beat == LAST_BEAT);

  assign m_axi.arid    = AXI_ID;
  assign m_axi.araddr  = rd_addr;
  assign m_axi.arlen   = LAST_BEAT;
  assign m_axi.arsize  = axi_size(DATA_W);
  assign m_axi.arburst = AXI_BURST_INCR;
  assign m_axi.arlock  = 1'b0;
  assign m_axi.arcache = 4'd0;
  assign m_axi.arprot  = 3'd0;
  assign m_axi.arqos   = 4'd0;

  assign aw_hs = m_axi.awvalid & m_axi.awready;
  assign w_hs  = m_axi.wvalid & m_axi.wready;
  assign b_hs  = m_axi.bvalid & m_axi.bready;
  assign ar_hs = m_axi.arvalid & m_axi.arready;
  assign r_hs  = m_axi.rvalid & m_axi.rready;

  assign wfifo_rd_en   = w_hs;
  assign rfifo_wr_en   = r_hs;
  assign rfifo_wr_data = m_axi.rdata;

  assign unused_in = ^{m_axi.bid, m_axi.rid,
                       m_axi.bresp, m_axi.rresp};

  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) w_st <= W_IDLE;
    else       w_st <= w_nx;
  end

  always_comb begin
    w_nx          = w_st;
    m_axi.awvalid = 1'b0;
    m_axi.wvalid  = 1'b0;
    m_axi.bready  = 1'b0;
    case (w_st)
      W_IDLE: if (wr_trig) w_nx = W_ADDR;
      W_ADDR: begin
        m_axi.awvalid = 1'b1;
        if (m_axi.awready) w_nx = W_DATA;
      end
      W_DATA: begin
        m_axi.wvalid = 1'b1;
        if (m_axi.wready && m_axi.wlast) w_nx = W_RESP;
      end
      W_RESP: begin
        m_axi.bready = 1'b1;
        if (m_axi.bvalid) w_nx = W_IDLE;
      end
      default: w_nx = W_IDLE;
    endcase
  end

  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst)     beat <= 8'd0;
    else if (w_hs) beat <= m_axi.wlast ? 8'd0 : beat + 8'd1;
  end

  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) r_st <= R_IDLE;
    else       r_st <= r_nx;
  end

  always_comb begin
    r_nx          = r_st;
    m_axi.arvalid = 1'b0;
    m_axi.rready  = 1'b0;
    case (r_st)
      R_IDLE: if (rd_trig) r_nx = R_ADDR;
      R_ADDR: begin
        m_axi.arvalid = 1'b1;
        if (m_axi.arready) r_nx = R_DATA;
      end
      R_DATA: begin
        m_axi.rready = 1'b1;
        if (m_axi.rvalid && m_axi.rlast) r_nx = R_IDLE;
      end
      default: r_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst)             last_done <= 2'd0;
    else if (wr_frame_end) last_done <= wr_buf_idx;
  end

  // two sync flops, third flop for edge detect
  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) vs_q <= 3'd0;
    else       vs_q <= {vs_q[1:0], rd_vsync};
  end

  assign vs_rise    = vs_q[1] & ~vs_q[2];
  // frame start only between bursts so a burst is never cut short
  assign rd_restart = vs_pend & (r_st == R_IDLE);

  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) vs_pend <= 1'b0;
    else       vs_pend <= (vs_pend & ~rd_restart) | vs_rise;
  end

  // never jump onto the buffer the writer is filling
  assign rd_load_idx = (last_done != wr_buf_idx) ? last_done
                                                 : rd_buf_idx;

  axi4_fb_addr_gen #(
    .ADDR_W      (ADDR_W),
    .FRAME_BYTES (FRAME_BYTES),
    .BURST_BYTES (BB),
    .FB_NUM      (FB_NUM),
    .FB_BASE     (FB_BASE),
    .RING_ADV    (1'b1)
  ) u_wr_addr (
    .sclk        (sclk),
    .s_rst       (s_rst),
    .step        (aw_hs),
    .restart     (1'b0),
    .restart_idx (2'd0),
    .addr        (wr_addr),
    .buf_idx     (wr_buf_idx),
    .frame_end   (wr_frame_end)
  );

  axi4_fb_addr_gen #(
    .ADDR_W      (ADDR_W),
    .FRAME_BYTES (FRAME_BYTES),
    .BURST_BYTES (BB),
    .FB_NUM      (FB_NUM),
    .FB_BASE     (FB_BASE),
    .RING_ADV    (1'b0)
  ) u_rd_addr (
    .sclk        (sclk),
    .s_rst       (s_rst),
    .step        (ar_hs),
    .restart     (rd_restart),
    .restart_idx (rd_load_idx),
    .addr        (rd_addr),
    .buf_idx     (rd_buf_idx),
    .frame_end   (rd_wrap_unused)
  );

`ifdef AXI4_FB_RESP_CHK_EN
  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      resp_err <= 2'b00;
    end else begin
      if (b_hs && m_axi.bresp != AXI_RESP_OKAY)
        resp_err[0] <= 1'b1;
      if (r_hs && m_axi.rresp != AXI_RESP_OKAY)
        resp_err[1] <= 1'b1;
    end
  end
`else
  assign resp_err = 2'b00;
`endif

endmodule

// File: tb/tb_axi4_fb_master.sv
// tb_axi4_fb_master: directed bench with a reactive AXI slave
// and hand-computed burst addresses for the 2-buffer 1 KiB config.
module tb_axi4_fb_master;

  localparam int DW = 128;
  localparam int AW = 28;

  logic          sclk = 1'b0;
  logic          s_rst;
  logic          wr_trig, wfifo_rd_en;
  logic [DW-1:0] wfifo_rd_data;
  logic          rd_trig, rd_vsync, rfifo_wr_en;
  logic [DW-1:0] rfifo_wr_data;
  logic [1:0]    wr_buf_idx, rd_buf_idx, resp_err;

  axi4_fb_master_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  axi4_fb_master #(
    .DATA_W      (DW),
    .ADDR_W      (AW),
    .BURST_LEN   (16),
    .FRAME_BYTES (1024),
    .FB_NUM      (2),
    .FB_BASE     (0)
  ) dut (
    .sclk          (sclk),
    .s_rst         (s_rst),
    .m_axi         (bus),
    .wr_trig       (wr_trig),
    .wfifo_rd_en   (wfifo_rd_en),
    .wfifo_rd_data (wfifo_rd_data),
    .rd_trig       (rd_trig),
    .rd_vsync      (rd_vsync),
    .rfifo_wr_en   (rfifo_wr_en),
    .rfifo_wr_data (rfifo_wr_data),
    .wr_buf_idx    (wr_buf_idx),
    .rd_buf_idx    (rd_buf_idx),
    .resp_err      (resp_err)
  );

  always #5 sclk = ~sclk;

  int tests = 0;
  int fails = 0;

  logic       aw_rdy, ar_rdy, w_tog;
  logic [1:0] bresp_cfg;

  logic [AW-1:0] aw_log[$];
  logic [AW-1:0] ar_log[$];
  logic [1:0]    aw_bi[$];
  int b_n = 0, w_n = 0, en_n = 0, last_n = 0, last_pos = 0;
  int r_n = 0, rl_n = 0, ren_n = 0, bad_n = 0;
  int b_pend = 0, r_left = 0, w_in = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge sclk);
    #2;
  endtask

  function automatic int cnt(input int sel);
    case (sel)
      0:       return aw_log.size();
      1:       return b_n;
      2:       return ar_log.size();
      3:       return rl_n;
      4:       return r_n;
      5:       return w_n;
      default: return 0;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int sel,
                          input int target);
    for (int i = 0; i < 3000; i++) begin
      if (cnt(sel) >= target) break;
      tick();
    end
    check(tag, 64'(cnt(sel) >= target), 64'd1);
  endtask

  task automatic wr_burst();
    int b0;
    b0 = b_n;
    wr_trig = 1'b1;
    tick();
    wr_trig = 1'b0;
    wait_for("wr_b_done", 1, b0 + 1);
    tick();
    tick();
  endtask

  task automatic rd_burst();
    int l0;
    l0 = rl_n;
    rd_trig = 1'b1;
    tick();
    rd_trig = 1'b0;
    wait_for("rd_last_done", 3, l0 + 1);
    tick();
    tick();
  endtask

  // slave model: drive at negedge, log the handshake due at next posedge
  initial begin
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    bus.bresp   = 2'b00;
    bus.bid     = 4'd0;
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rlast   = 1'b0;
    bus.rdata   = '0;
    bus.rresp   = 2'b00;
    bus.rid     = 4'd0;
    wfifo_rd_data = '0;
    forever begin
      @(negedge sclk);
      if (s_rst) begin
        b_pend = 0;
        r_left = 0;
        w_in   = 0;
      end
      bus.awready   = aw_rdy;
      bus.arready   = ar_rdy;
      bus.wready    = w_tog ? ~bus.wready : 1'b1;
      bus.bvalid    = (b_pend > 0);
      bus.bresp     = bresp_cfg;
      bus.rvalid    = (r_left > 0);
      bus.rlast     = (r_left == 1);
      bus.rdata     = DW'(r_n + 32'h1000);
      wfifo_rd_data = DW'(w_n + 32'h5000);
      #1;
      if (bus.awvalid && bus.awready) begin
        aw_log.push_back(bus.awaddr);
        aw_bi.push_back(wr_buf_idx);
      end
      if (wfifo_rd_en) en_n++;
      if (wfifo_rd_en !== (bus.wvalid && bus.wready)) bad_n++;
      if (bus.wvalid && bus.wready) begin
        if (bus.wdata !== wfifo_rd_data) bad_n++;
        w_n++;
        w_in++;
        if (bus.wlast) begin
          last_n++;
          last_pos = w_in;
          w_in = 0;
          b_pend++;
        end
      end
      if (bus.bvalid && bus.bready) begin
        b_n++;
        b_pend--;
      end
      if (bus.arvalid && bus.arready) begin
        ar_log.push_back(bus.araddr);
        r_left += 16;
      end
      if (bus.rvalid && bus.rready) begin
        r_n++;
        r_left--;
        if (bus.rlast) rl_n++;
      end
      if (rfifo_wr_en) begin
        ren_n++;
        if (rfifo_wr_data !== bus.rdata) bad_n++;
      end
      if (rfifo_wr_en !== (bus.rvalid && bus.rready)) bad_n++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, l0, r0, q0, a0, w0;
    logic [1:0] exp_err;
    s_rst     = 1'b1;
    wr_trig   = 1'b0;
    rd_trig   = 1'b0;
    rd_vsync  = 1'b0;
    aw_rdy    = 1'b1;
    ar_rdy    = 1'b1;
    w_tog     = 1'b0;
    bresp_cfg = 2'b00;
    repeat (3) tick();

    check("rst_valids", {bus.awvalid, bus.wvalid, bus.bready,
                         bus.arvalid, bus.rready}, 0);
    check("rst_buf_idx", {wr_buf_idx, rd_buf_idx}, 0);
    check("rst_resp_err", resp_err, 0);
    s_rst = 1'b0;
    tick();
    check("awlen", bus.awlen, 15);
    check("awsize", bus.awsize, 4);
    check("arburst", bus.arburst, 1);
    check("wstrb", bus.wstrb, 64'hffff);

    // six back-to-back write bursts
    wr_trig = 1'b1;
    wait_for("t1_aw_wait", 0, 6);
    wr_trig = 1'b0;
    wait_for("t1_b_wait", 1, 6);
    repeat (4) tick();
    check("t1_aw_count", aw_log.size(), 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("t1_aw%0d", i), aw_log[i], 64'(i * 256));
    check("t1_bi_aw3", aw_bi[3], 0);
    check("t1_bi_aw4", aw_bi[4], 1);
    check("t1_wbeats", w_n, 96);
    check("t1_wfifo_en", en_n, 96);
    check("t1_wlast_n", last_n, 6);
    check("t1_wr_buf", wr_buf_idx, 1);

    // wready toggling
    w_tog = 1'b1;
    e0 = en_n;
    l0 = last_n;
    wr_burst();
    w_tog = 1'b0;
    check("t2_aw", aw_log[6], 64'h600);
    check("t2_en_pulses", en_n - e0, 16);
    check("t2_wlast_n", last_n - l0, 1);
    check("t2_wlast_pos", last_pos, 16);

    // finish buffer 1: writer wraps to buffer 0
    wr_burst();
    check("t2b_aw", aw_log[7], 64'h700);
    check("t2b_wr_buf", wr_buf_idx, 0);

    // five reads without vsync
    rd_trig = 1'b1;
    wait_for("t3_ar_wait", 2, 5);
    rd_trig = 1'b0;
    wait_for("t3_rl_wait", 3, 5);
    repeat (3) tick();
    for (int i = 0; i < 5; i++)
      check($sformatf("t3_ar%0d", i), ar_log[i],
            64'((i % 4) * 256));
    check("t3_rd_buf", rd_buf_idx, 0);
    check("t3_beats", r_n, 80);
    check("t3_rfifo_en", ren_n, 80);

    // vsync during beat 7
    r0 = r_n;
    q0 = rl_n;
    a0 = ar_log.size();
    rd_trig = 1'b1;
    tick();
    rd_trig = 1'b0;
    wait_for("t4_beat7", 4, r0 + 7);
    rd_vsync = 1'b1;
    repeat (3) tick();
    rd_vsync = 1'b0;
    wait_for("t4_rl_wait", 3, q0 + 1);
    repeat (6) tick();
    check("t4_beats", r_n - r0, 16);
    check("t4_ar0", ar_log[a0], 64'h100);
    rd_burst();
    check("t4_ar1", ar_log[a0 + 1], 64'h400);
    check("t4_rd_buf", rd_buf_idx, 1);

    // reset during W_DATA
    w_tog = 1'b1;
    w0 = w_n;
    wr_trig = 1'b1;
    tick();
    wr_trig = 1'b0;
    wait_for("t5_w_wait", 5, w0 + 3);
    check("t5_pre_wvalid", bus.wvalid, 1);
    s_rst = 1'b1;
    #1;
    check("t5_rst_valids", {bus.awvalid, bus.wvalid, bus.bready,
                            bus.arvalid, bus.rready}, 0);
    check("t5_rst_buf", {wr_buf_idx, rd_buf_idx}, 0);
    tick();
    tick();
    s_rst = 1'b0;
    w_tog = 1'b0;
    tick();
    a0 = aw_log.size();
    wr_burst();
    check("t5_aw_after", aw_log[a0], 64'h000);

    // error response
`ifdef AXI4_FB_RESP_CHK_EN
    exp_err = 2'b01;
`else
    exp_err = 2'b00;
`endif
    bresp_cfg = 2'b10;
    wr_burst();
    bresp_cfg = 2'b00;
    check("t6_resp_err", resp_err, exp_err);
    wr_burst();
    check("t6_resp_hold", resp_err, exp_err);
    check("t6_aw", aw_log[$], 64'h200);

    check("datapath_errs", bad_n, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi4_fb_master.md
AXI4_FB_MASTER -- requirements
Module: axi4_fb_master

Interface
REQ-001 SHALL have parameter DATA_W, default 128: AXI data width in bits (64, 128 or 256).
REQ-002 SHALL have parameter ADDR_W, default 28: AXI byte-address width.
REQ-003 SHALL have parameter BURST_LEN, default 16: beats per burst (1..256); awlen and arlen = BURST_LEN-1.
REQ-004 SHALL have parameter FRAME_BYTES, default 1920*1080*2: bytes per frame, an integer multiple of BURST_BYTES = BURST_LEN*DATA_W/8.
REQ-005 SHALL have parameter FB_NUM, default 3: frame buffers in the ring (1..4), laid out back-to-back.
REQ-006 SHALL have parameter FB_BASE, default 0: byte address of buffer 0.
REQ-007 SHALL have ports sclk (in, 1, clock) and s_rst (in, 1); reset is asynchronous and active-high; one clock domain only.
REQ-008 SHALL have full AXI4 master AW/W/B/AR/R ports (m_axi_*); data DATA_W, strobe DATA_W/8, address ADDR_W, id 4.
REQ-009 SHALL have wr_trig (in, 1): write FIFO holds at least one burst; wfifo_rd_en (out, 1); wfifo_rd_data (in, DATA_W).
REQ-010 SHALL have rd_trig (in, 1): read FIFO has room for one burst; rd_vsync (in, 1, asynchronous frame start); rfifo_wr_en (out, 1); rfifo_wr_data (out, DATA_W).
REQ-011 SHALL have wr_buf_idx and rd_buf_idx (out, 2 each) and resp_err (out, 2: bit0 write, bit1 read).

Function
REQ-012 SHALL tie constant fields: id 0, size log2(DATA_W/8), burst INCR, lock/cache/prot/qos 0, wstrb all ones.
REQ-013 SHALL run write FSM W_IDLE->W_ADDR on wr_trig; W_ADDR->W_DATA on awvalid&awready; W_DATA->W_RESP on the wlast handshake; W_RESP->W_IDLE on bvalid&bready.
REQ-014 SHALL assert awvalid only in W_ADDR, wvalid only in W_DATA, and bready only in W_RESP; all valids held until their handshake.
REQ-015 SHALL drive wfifo_rd_en = wvalid&wready, wdata = wfifo_rd_data (FWFT), and wlast high on beat BURST_LEN-1 of an 8-bit beat counter.
REQ-016 SHALL run read FSM R_IDLE->R_ADDR on rd_trig; R_ADDR->R_DATA on arvalid&arready; R_DATA->R_IDLE on the rlast handshake; rready high only in R_DATA.
REQ-017 SHALL drive rfifo_wr_en = rvalid&rready and rfifo_wr_data = rdata.
REQ-018 SHALL form each address as FB_BASE + buf_idx*FRAME_BYTES + offset, computed at ADDR_W bits with no truncation for legal parameters.
REQ-019 SHALL add BURST_BYTES to the write offset on aw handshake; at FRAME_BYTES-BURST_BYTES it wraps to 0 and wr_buf_idx advances modulo FB_NUM.
REQ-020 SHALL record the buffer just completed as last_done.
REQ-021 SHALL synchronise rd_vsync through two flops; on its rising edge SHALL set a pending flag.
REQ-022 SHALL apply a pending frame start only in R_IDLE: read offset <- 0, rd_buf_idx <- last_done; an in-flight burst is never truncated.
REQ-023 SHALL, when the read offset reaches frame end without a vsync, wrap to 0 and keep rd_buf_idx.
REQ-024 SHALL never advance rd_buf_idx onto wr_buf_idx; with FB_NUM=1 both stay 0.
REQ-025 SHALL let write and read channels operate concurrently and independently.

Reset
REQ-026 SHALL clear on s_rst: all valid/ready outputs 0, both FSMs idle, offsets 0, wr_buf_idx 0, rd_buf_idx 0, last_done 0, pending 0, resp_err 0, beat counter 0.
REQ-027 SHALL treat reset mid-burst as abort; no completion of an outstanding burst is required.

Configuration
REQ-028 SHALL, with macro AXI4_FB_RESP_CHK_EN defined, set resp_err[0] sticky on any bresp!=0 and resp_err[1] on any rresp!=0 handshake, cleared only by reset; without it, resp_err is constant 0 and no check logic exists.

Structure
REQ-029 SHALL place FSM state enums, AXI burst/size/resp constants and the BURST_BYTES calculation in shared package axi4_fb_pkg.
REQ-030 SHALL implement buffer-ring and offset arithmetic in sub-module axi4_fb_addr_gen, instantiated once per channel.

Verification (DATA_W=128, BURST_LEN=16, FRAME_BYTES=1024, FB_NUM=2, FB_BASE=0)
REQ-031 SHALL cover: wr_trig held, slave always ready -> AW at 0x000,0x100,0x200,0x300,0x400,0x500; wr_buf_idx 0->1 after fourth AW.
REQ-032 SHALL cover: wready toggled every other cycle -> exactly 16 wfifo_rd_en pulses per burst; wlast on the 16th only.
REQ-033 SHALL cover: rd_vsync pulse during beat 7 of a read burst -> all 16 beats accepted; next araddr = 0x400 (last_done=1).
REQ-034 SHALL cover: no vsync over 5 read bursts -> araddr 0x000..0x300 then 0x000, same buffer.
REQ-035 SHALL cover: s_rst asserted mid W_DATA -> all valids 0 asynchronously; next AW at 0x000.
REQ-036 SHALL cover: bresp=2'b10 with AXI4_FB_RESP_CHK_EN -> resp_err=2'b01 persisting; same stimulus without the macro -> resp_err 0.
